// File: rtl/div_unit.sv
// Iterative restoring integer divider for the EX stage (RISC-V DIV/DIVU/REM/REMU).
// One quotient bit per cycle. While an operation is in flight, stall_o holds the upstream pipeline.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic             is_rem_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] result_q;
    logic             rem_mode_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign a_neg = is_signed_i & a_i[WIDTH-1];
    assign b_neg = is_signed_i & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // The dividend is shifted out of quo_q's MSB into the partial remainder.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvsr_q};
    assign diff    = shifted[WIDTH-1:0] - dvsr_q;
    assign rem_d   = ge ? diff : shifted[WIDTH-1:0];
    assign quo_d   = {quo_q[WIDTH-2:0], ge};
    assign q_fin   = q_neg_q ? -quo_d : quo_d;
    assign r_fin   = r_neg_q ? -rem_d : rem_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            result_q   <= '0;
            rem_mode_q <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        rem_mode_q <= is_rem_i;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        rem_q      <= '0;
                        quo_q      <= a_mag;
                        dvsr_q     <= b_mag;
                        count_q    <= '0;
                        if (b_i == '0) begin
                            result_q <= is_rem_i ? a_i : '1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q   <= rem_d;
                        quo_q   <= quo_d;
                        count_q <= count_q + 1'b1;
                        if (count_q == CW'(WIDTH - 1)) begin
                            result_q <= rem_mode_q ? r_fin : q_fin;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_o  = ((state_q == IDLE) && start_i && !flush_i) || (state_q == BUSY);
    assign busy_o   = (state_q == BUSY);
    assign done_o   = (state_q == DONE) && !flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, random ops against an
// arithmetic reference model, and hand-written flush/reset/back-to-back sequences.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, is_signed, is_rem, flush;
    logic [W-1:0] a, b;
    logic         stall, busy, done;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .is_signed_i(is_signed),
        .is_rem_i(is_rem), .flush_i(flush), .a_i(a), .b_i(b),
        .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vs;
        logic         vr;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s, input logic r);
        int signed sx, sy;
        if (y == 0) return r ? x : '1;
        if (s) begin
            sx = x;
            sy = y;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
            return r ? W'(sx % sy) : W'(sx / sy);
        end
        return r ? x % y : x / y;
    endfunction

    // Starts one op on the next edge, checks stall over the whole op, done latency and result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                          input logic tr, input logic [W-1:0] exp, input int lat, input string nm);
        int  cyc = 0;
        bit  seen = 0;
        bit  seq_ok = 1;
        @(posedge clk); #1;
        a = ta; b = tb_; is_signed = ts; is_rem = tr; start = 1'b1;
        while (!seen && cyc <= lat + 5) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check({nm, " latency"}, W'(cyc), W'(lat));
                check({nm, " stall@done"}, W'(stall), 0);
                check({nm, " result"}, result, exp);
            end else if (!stall) begin
                seq_ok = 0;
            end
            cyc++;
        end
        if (!seen) check({nm, " done timeout"}, 0, 1);
        check({nm, " stall held"}, W'(seq_ok), 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] prev, ra, rb, e;
        logic         rs, rr;
        int           done_cnt;

        reset = 1'b1; start = 0; is_signed = 0; is_rem = 0; flush = 0; a = 0; b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", W'(stall), 0);
        check("reset busy", W'(busy), 0);
        check("reset done", W'(done), 0);
        check("reset result", result, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        vecs[0] = '{32'd100,       32'd7,          0, 0, 32'd14,        33};
        vecs[1] = '{32'hFFFF_FF9C, 32'd7,          1, 0, 32'hFFFF_FFF2, 33};
        vecs[2] = '{32'hFFFF_FF9C, 32'd7,          1, 1, 32'hFFFF_FFFE, 33};
        vecs[3] = '{32'd100,       32'hFFFF_FFF9,  1, 1, 32'd2,         33};
        vecs[4] = '{32'd5,         32'd0,          0, 0, 32'hFFFF_FFFF, 1};
        vecs[5] = '{32'd5,         32'd0,          0, 1, 32'd5,         1};
        vecs[6] = '{32'hFFFF_FFFB, 32'd0,          1, 1, 32'hFFFF_FFFB, 1};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF,  1, 0, 32'h8000_0000, 33};
        vecs[8] = '{32'h8000_0000, 32'hFFFF_FFFF,  1, 1, 32'h0,         33};
        vecs[9] = '{32'hFFFF_FFFF, 32'd1,          0, 0, 32'hFFFF_FFFF, 33};
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vr, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            e  = ref_div(ra, rb, rs, rr);
            run_op(ra, rb, rs, rr, e, (rb == 0) ? 1 : W + 1, $sformatf("rnd%0d", i));
        end

        // Flush in IDLE blocks accept.
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; is_signed = 0; is_rem = 0; start = 1; flush = 1;
        @(negedge clk);
        check("idle flush stall", W'(stall), 0);
        @(posedge clk); #1;
        start = 0; flush = 0;
        @(negedge clk);
        check("idle flush busy", W'(busy), 0);

        // Flush in BUSY cycle 10.
        prev = result;
        @(posedge clk); #1;
        start = 1;
        repeat (10) @(posedge clk);
        #1; flush = 1; start = 0;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        check("flush busy", W'(busy), 0);
        check("flush stall", W'(stall), 0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("flush no done", W'(done_cnt), 0);
        check("flush result kept", result, prev);

        // Reset in BUSY cycle 10.
        @(posedge clk); #1;
        start = 1;
        repeat (10) @(posedge clk);
        #1; reset = 1; start = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("rst busy", W'(busy), 0);
        check("rst result", result, 0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst no done", W'(done_cnt), 0);

        // Back-to-back with operands changed during the first op.
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; is_signed = 0; is_rem = 0; start = 1;
        done_cnt = 0;
        for (int c = 0; c <= 67; c++) begin
            @(negedge clk);
            if (c == 5) begin a = 32'd9; b = 32'd2; end
            if (c == 33) begin
                check("b2b done1", W'(done), 1);
                check("b2b result1", result, 32'd14);
                check("b2b stall33", W'(stall), 0);
            end else if (c == 34) begin
                check("b2b stall34", W'(stall), 1);
            end else if (c == 67) begin
                check("b2b done2", W'(done), 1);
                check("b2b result2", result, 32'd4);
            end else if (done) begin
                done_cnt++;
            end
        end
        check("b2b stray done", W'(done_cnt), 0);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("b2b idle after", W'(busy | done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
